// File: rtl/serial_subtractor_c.sv
// Bit-serial subtractor: x - y - bz computed LSB-first, one bit per clock,
// under a start/busy/done handshake.
module serial_subtractor_c #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  input  logic             bzin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] fdiff,
  output logic             fbout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_xr;
  logic [WIDTH-1:0] r_yr;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_fdiff;
  logic             r_fbout;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nx;

  assign w_a      = r_xr[0];
  assign w_b      = r_yr[0];
  assign w_d      = w_a ^ w_b ^ r_br;
  assign w_bo     = (~w_a & w_b) | (~w_a & r_br) | (w_b & r_br);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_res_nx = {w_d, r_res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result fills from the MSB end so it is aligned after WIDTH shifts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xr    <= '0;
      r_yr    <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_fdiff <= '0;
      r_fbout <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xr  <= xin;
            r_yr  <= yin;
            r_br  <= bzin;
            r_cnt <= '0;
            r_res <= '0;
          end
        end
        S_RUN: begin
          r_res <= w_res_nx;
          r_xr  <= r_xr >> 1;
          r_yr  <= r_yr >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_fdiff <= w_res_nx;
            r_fbout <= w_bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign fdiff = r_fdiff;
  assign fbout = r_fbout;

endmodule

// File: tb/tb_serial_subtractor_c.sv
// Scoreboard bench for serial_subtractor_c: driver queues expected
// results, a negedge monitor checks every done pulse and output hold.
module tb_serial_subtractor_c;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] xin;
  logic [W-1:0] yin;
  logic         bzin;
  logic         busy;
  logic         done;
  logic [W-1:0] fdiff;
  logic         fbout;

  serial_subtractor_c #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .xin   (xin),
    .yin   (yin),
    .bzin  (bzin),
    .busy  (busy),
    .done  (done),
    .fdiff (fdiff),
    .fbout (fbout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   cyc     = 0;
  logic [W:0] held = '0;

  always @(posedge clk) cyc++;

  function automatic logic [W:0] model(int x, int y, int bz);
    int e;
    e = x - y - bz;
    model[W]     = (e < 0);
    model[W-1:0] = W'(e + (1 << W));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = '0;
    end else begin
      n_tests++;
      if (busy !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL busy: got %b want %b at cyc %0d",
                 busy, q.size() != 0, cyc);
      end
      if (done === 1'b1) begin
        n_done++;
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_done: got done=1 want no pending op");
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({fbout, fdiff} !== e.res) begin
            n_fail++;
            $display("FAIL result: got fbout=%b fdiff=%0d want fbout=%b fdiff=%0d",
                     fbout, fdiff, e.res[W], e.res[W-1:0]);
          end
          n_tests++;
          if (cyc - e.acc != W) begin
            n_fail++;
            $display("FAIL latency: got %0d want %0d", cyc - e.acc, W);
          end
          held = e.res;
        end
      end else begin
        n_tests++;
        if ({fbout, fdiff} !== held) begin
          n_fail++;
          $display("FAIL hold: got %h want %h", {fbout, fdiff}, held);
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 50);
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b want 0", busy);
    end
  endtask

  task automatic issue(input int x, input int y, input int bz);
    exp_t e;
    @(posedge clk);
    #1;
    xin   = W'(x);
    yin   = W'(y);
    bzin  = 1'(bz);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.res = model(x, y, bz);
    e.acc = cyc;
    q.push_back(e);
    xin   = W'($urandom);
    yin   = W'($urandom);
    bzin  = 1'($urandom);
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic run(input int x, input int y, input int bz);
    wait_idle();
    issue(x, y, bz);
    wait_empty();
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    xin   = '0;
    yin   = '0;
    bzin  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, fbout, fdiff} !== '0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b fbout=%b fdiff=%0d want all 0",
               busy, done, fbout, fdiff);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    run(23410, 16234, 0);
    run(16234, 23410, 1);
    run(0, 0, 1);
    run(65535, 65535, 0);

    wait_idle();
    issue(23410, 16234, 0);
    repeat (4) @(posedge clk);
    #1;
    xin   = 16'd1;
    yin   = 16'd1;
    bzin  = 1'b0;
    start = 1'b1;
    repeat (9) @(posedge clk);
    #1 start = 1'b0;
    wait_empty();

    wait_idle();
    issue(23410, 16234, 0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, fbout, fdiff} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy=%b fbout=%b fdiff=%0d want 0",
               busy, fbout, fdiff);
    end
    repeat (25) @(negedge clk);
    run(23410, 16234, 0);

    d0 = n_done;
    for (int i = 0; i < 1000; i++) begin
      run(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
          int'($urandom_range(0, 1)));
    end
    n_tests++;
    if (n_done - d0 != 1000) begin
      n_fail++;
      $display("FAIL done_count: got %0d want 1000", n_done - d0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
